// File: rtl/cfg_serial_rx_node.sv
// Config-network receive node: parses framed serial packets, updates a config
// register on an ID match, and re-drives the raw stream one cycle late.
module cfg_serial_rx_node #(
  parameter int unsigned id_width_p   = 8,
  parameter int unsigned data_width_p = 16,
  parameter logic [id_width_p-1:0]   id_p      = '0,
  parameter logic [data_width_p-1:0] default_p = '0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    bit_i,
  output logic                    bit_o,
  output logic [data_width_p-1:0] data_o,
  output logic                    v_o,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int unsigned ID_W  = id_width_p;
  localparam int unsigned D_W   = data_width_p;
  localparam int unsigned MAX_W = (ID_W > D_W) ? ID_W : D_W;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ID     = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_RESYNC = 3'd5
  } state_e;

  state_e state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  id_sr;
  logic [D_W-1:0]   data_sr;
  logic             acc;
  logic             parity_ok;

  logic cnt_clr, cnt_inc, acc_clr, acc_fold;
  logic shift_id, shift_data, par_ld, load;
  logic v_next, err_next, busy_next;

  logic last_id, last_data;
  assign last_id   = (cnt == CNT_W'(ID_W - 1));
  assign last_data = (cnt == CNT_W'(D_W - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (!bit_i) state_next = S_ID;
      S_ID:     if (last_id) state_next = S_DATA;
      S_DATA:   if (last_data) state_next = S_PARITY;
      S_PARITY: state_next = S_STOP;
      S_STOP:   state_next = bit_i ? S_IDLE : S_RESYNC;
      S_RESYNC: if (bit_i) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath controls and next values of the registered outputs
  always_comb begin
    cnt_clr    = (state_next != state);
    cnt_inc    = 1'b0;
    acc_clr    = 1'b0;
    acc_fold   = 1'b0;
    shift_id   = 1'b0;
    shift_data = 1'b0;
    par_ld     = 1'b0;
    load       = 1'b0;
    v_next     = 1'b0;
    err_next   = 1'b0;
    busy_next  = (state_next != S_IDLE);
    case (state)
      S_IDLE: acc_clr = 1'b1;
      S_ID: begin
        shift_id = 1'b1;
        acc_fold = 1'b1;
        cnt_inc  = 1'b1;
      end
      S_DATA: begin
        shift_data = 1'b1;
        acc_fold   = 1'b1;
        cnt_inc    = 1'b1;
      end
      S_PARITY: par_ld = 1'b1;
      S_STOP: begin
        // A mismatched ID with good framing and parity is silently dropped
        if (!bit_i || !parity_ok) begin
          err_next = 1'b1;
        end else if (id_sr == id_p) begin
          load   = 1'b1;
          v_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Shift registers, counter, parity and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bit_o     <= 1'b1;
      data_o    <= default_p;
      v_o       <= 1'b0;
      err_o     <= 1'b0;
      busy_o    <= 1'b0;
      cnt       <= '0;
      id_sr     <= '0;
      data_sr   <= '0;
      acc       <= 1'b0;
      parity_ok <= 1'b0;
    end else begin
      bit_o  <= bit_i;
      v_o    <= v_next;
      err_o  <= err_next;
      busy_o <= busy_next;
      if (load) data_o <= data_sr;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (acc_clr)       acc <= 1'b0;
      else if (acc_fold) acc <= acc ^ bit_i;
      // LSB-first fields: new bits enter at the MSB and shift down
      if (shift_id)   id_sr   <= ID_W'({bit_i, id_sr} >> 1);
      if (shift_data) data_sr <= D_W'({bit_i, data_sr} >> 1);
      if (par_ld)     parity_ok <= ~(acc ^ bit_i);
    end
  end

endmodule

// File: tb/tb_cfg_serial_rx_node.sv
// Directed bench for cfg_serial_rx_node: match, mismatch, parity, framing,
// mid-packet reset and back-to-back packets.
module tb_cfg_serial_rx_node;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       bit_i;
  logic       bit_o;
  logic [7:0] data_o;
  logic       v_o;
  logic       err_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int v_cyc_a, v_cyc_b;

  cfg_serial_rx_node #(
    .id_width_p  (4),
    .data_width_p(8),
    .id_p        (4'd5),
    .default_p   (8'h3C)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bit_i  (bit_i),
    .bit_o  (bit_o),
    .data_o (data_o),
    .v_o    (v_o),
    .err_o  (err_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one bit, let the edge sample it, then look at the outputs
  task automatic send_bit(input logic b);
    bit_i = b;
    @(posedge clk_i);
    #1;
    check_val("bit_o", 32'(bit_o), 32'(b));
  endtask

  task automatic send_packet(input logic [3:0] id, input logic [7:0] data,
                             input logic flip, input logic stop,
                             input logic exp_v, input logic exp_err,
                             input logic [7:0] exp_data);
    logic par;
    par = (^id) ^ (^data) ^ flip;
    send_bit(1'b0);
    check_val("busy_after_start", 32'(busy_o), 32'd1);
    for (int i = 0; i < 4; i++) send_bit(id[i]);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(par);
    check_val("busy_in_stop", 32'(busy_o), 32'd1);
    check_val("v_before_stop", 32'(v_o), 32'd0);
    send_bit(stop);
    if (v_o) v_cyc_b = cyc;
    check_val("v_after_stop", 32'(v_o), 32'(exp_v));
    check_val("err_after_stop", 32'(err_o), 32'(exp_err));
    check_val("data_after_stop", 32'(data_o), 32'(exp_data));
    check_val("busy_after_stop", 32'(busy_o), 32'(!stop));
  endtask

  initial begin
    reset_i = 1'b1;
    bit_i   = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_data", 32'(data_o), 32'h3C);
    check_val("rst_bit_o", 32'(bit_o), 32'd1);
    check_val("rst_v", 32'(v_o), 32'd0);
    check_val("rst_err", 32'(err_o), 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    send_bit(1'b1);
    check_val("idle_busy", 32'(busy_o), 32'd0);

    // Matching packet: parity bit = (2 ones in ID + 5 in A7) odd -> 1
    send_packet(4'h5, 8'hA7, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA7);
    send_bit(1'b1);
    check_val("v_one_cycle", 32'(v_o), 32'd0);
    check_val("data_hold", 32'(data_o), 32'hA7);

    // Non-matching ID
    send_packet(4'h6, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA7);
    send_bit(1'b1);

    // Parity error
    send_packet(4'h5, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA7);
    send_bit(1'b1);
    check_val("err_one_cycle", 32'(err_o), 32'd0);

    // Framing error, line held low, then recovery
    send_packet(4'h5, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA7);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0);
      check_val("resync_busy", 32'(busy_o), 32'd1);
      check_val("resync_err", 32'(err_o), 32'd0);
    end
    send_bit(1'b1);
    check_val("resync_exit_busy", 32'(busy_o), 32'd0);
    send_packet(4'h5, 8'h42, 1'b0, 1'b1, 1'b1, 1'b0, 8'h42);
    send_bit(1'b1);

    // Reset after six data bits of a partial packet
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 0 || i == 2);
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    reset_i = 1'b1;
    bit_i   = 1'b1;
    @(posedge clk_i);
    #1;
    check_val("midrst_data", 32'(data_o), 32'h3C);
    check_val("midrst_busy", 32'(busy_o), 32'd0);
    check_val("midrst_v", 32'(v_o), 32'd0);
    reset_i = 1'b0;
    send_bit(1'b1);

    // Back-to-back packets, second start right after first stop
    v_cyc_b = 0;
    send_packet(4'h5, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01);
    v_cyc_a = v_cyc_b;
    send_packet(4'h5, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02);
    check_val("b2b_spacing", 32'(v_cyc_b - v_cyc_a), 32'd15);
    send_bit(1'b1);
    check_val("b2b_final_data", 32'(data_o), 32'h02);
    check_val("b2b_v_low", 32'(v_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cfg_serial_rx_node.md
Name: cfg_serial_rx_node

Overview:
- Receive side of the legacy config network. Sits directly downstream of the NAND-based metastability/relay stage.
- Consumes its already-synchronized serial config bit and parses framed packets.
- When a packet's ID matches this node, updates a parallel configuration register.
- Re-drives the bit stream, delayed one cycle, to the next node in the chain.

Parameters:
- id_p, 0: this node's ID; packets carrying this ID are accepted.
- id_width_p, 8: ID field width in bits (>=1).
- data_width_p, 16: payload width in bits (>=1).
- default_p, 0: value of data_o after reset (data_width_p bits).

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  synchronous, active-high reset.
- bit_i  in  1  serial config bit, already synchronized upstream; idle level 1.
- bit_o  out  1  bit_i registered one cycle, for chaining to the next node.
- data_o  out  data_width_p  current configuration value.
- v_o  out  1  one-cycle pulse: data_o was just updated by a matching, error-free packet.
- err_o  out  1  one-cycle pulse: parity or framing error on any packet.
- busy_o  out  1  high while a packet is being parsed (state != IDLE).

Behaviour:
- Packet format: start bit 0; then id_width_p ID bits, LSB first; then data_width_p data bits, LSB first; then 1 parity bit; then stop bit 1.
- Parity is even: ID bits + data bits + parity bit together contain an even number of ones.
- One bit is sampled per clock edge, from bit_i.
- Reset values: data_o=default_p, v_o=0, err_o=0, busy_o=0, bit_o=1, state=IDLE, all shift registers and counters cleared.
- States and transitions:
  - IDLE: bit_i=0 -> ID (counter cleared); otherwise stay.
  - ID: shift bit into id shift register; after id_width_p bits -> DATA.
  - DATA: shift into data shift register and fold each bit into a running parity accumulator; after data_width_p bits -> PARITY. (ID bits are also folded into the accumulator.)
  - PARITY: sample the parity bit and compute parity_ok -> STOP.
  - STOP, bit_i=1 -> IDLE. If parity_ok and ID == id_p: data_o <= data shift register and v_o=1 in the next cycle. If parity is bad: err_o=1 in the next cycle and data_o is unchanged.
  - STOP, bit_i=0 (framing error) -> RESYNC; err_o=1 in the next cycle; data_o unchanged.
  - RESYNC: stay until bit_i=1, then -> IDLE. A line held at 0 is never taken as a new start bit.
- Latency: v_o and the data_o update appear exactly one cycle after the clock edge that samples the stop bit.
- v_o and err_o are never asserted in the same cycle.
- A packet whose ID does not match is parsed fully (parity and framing still checked, err_o may pulse) but never updates data_o or asserts v_o.
- Back-to-back packets: a start bit in the cycle immediately after the stop bit is accepted (IDLE samples it).
- Bit counter width is clog2(max(id_width_p, data_width_p)+1). It is cleared on every state change and never wraps within a field.
- Reset mid-packet: the partial packet is discarded, the FSM returns to IDLE, and data_o returns to default_p.
- bit_o is independent of parsing: always bit_i delayed one cycle, including during RESYNC.

Test Plan:
- Reset (id_p=5, id_width_p=4, data_width_p=8, default_p=8'h3C), line idle at 1 -> data_o=8'h3C, bit_o=1, v_o=err_o=busy_o=0.
- Matching packet: start, ID=4'h5, data=8'hA7, correct parity, stop -> one cycle after stop is sampled, v_o=1 for one cycle and data_o=8'hA7. busy_o is high from the cycle after the start bit through the stop cycle. bit_o mirrors the stream delayed one cycle.
- Non-matching packet: ID=4'h6, data=8'h11, good parity -> no v_o, no err_o, data_o stays 8'hA7.
- Parity error: ID=5, data=8'hFF, flipped parity bit -> err_o pulses one cycle after stop, data_o unchanged, v_o=0.
- Framing error, then recovery: stop bit=0 and line held at 0 for 5 cycles -> err_o pulse, no new packet starts (busy_o stays high in RESYNC). The line then goes to 1 and a valid packet (ID=5, data=8'h42) follows -> v_o pulse, data_o=8'h42.
- Reset mid-packet after 6 data bits, followed by a back-to-back pair of valid packets (data 8'h01 then 8'h02, second start bit immediately after first stop bit) -> after reset data_o=8'h3C. Then two v_o pulses, exactly 15 cycles apart (1 start + 4 ID + 8 data + 1 parity + 1 stop), ending with data_o=8'h02.
